// File: rtl/id_ex_stage_pkg.sv
// Shared types for the ID/EX pipeline register: ALU operation classes, control bundle, default width.
// No logic; imported by id_ex_stage and load_use_detector.
package id_ex_stage_pkg;

  localparam int XLEN_DEF = 32;

  typedef enum logic [1:0] {
    ALUOP_ADD    = 2'b00,
    ALUOP_BRANCH = 2'b01,
    ALUOP_FUNCT  = 2'b10,
    ALUOP_IMM    = 2'b11
  } alu_op_e;

  typedef struct packed {
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    mem_to_reg;
    logic    branch;
    logic    alu_src;
    alu_op_e alu_op;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

endpackage

// File: rtl/id_ex_stage_load_use_detector.sv
// Flags a load in EX whose destination is read by the instruction in ID; purely combinational.
// Latency 0; the result drives the upstream stall and the bubble insert.
module load_use_detector
  import id_ex_stage_pkg::*;
(
  input  logic       ex_valid,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd,
  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  output logic       load_use
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit  = id_use_rs1 && (ex_rd == id_rs1);
  assign rs2_hit  = id_use_rs2 && (ex_rd == id_rs2);
  // x0 is never a real dependency, so a load to x0 cannot stall
  assign load_use = ex_valid && ex_mem_read && (ex_rd != 5'd0) && id_valid && (rs1_hit || rs2_hit);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush, hold and saturating perf counters.
// Latency 1 clock; ex_hold freezes the stage, load-use stalls PC/IF-ID for exactly one cycle.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_id_valid,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [XLEN-1:0]  id_rdata1,
  input  logic [XLEN-1:0]  id_rdata2,
  input  logic [XLEN-1:0]  id_imm,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             id_RegWrite,
  input  logic             id_MemRead,
  input  logic             id_MemWrite,
  input  logic             id_MemtoReg,
  input  logic             id_Branch,
  input  logic             id_ALUSrc,
  input  logic [1:0]       id_ALUOp,
  input  logic             ex_flush,
  input  logic             ex_hold,
  output logic             ID_EX_valid,
  output logic [XLEN-1:0]  ID_EX_PC,
  output logic [XLEN-1:0]  ID_EX_RData1,
  output logic [XLEN-1:0]  ID_EX_RData2,
  output logic [XLEN-1:0]  ID_EX_Imm,
  output logic [4:0]       ID_EX_RS1,
  output logic [4:0]       ID_EX_RS2,
  output logic [4:0]       ID_EX_RD,
  output logic             ID_EX_RegWrite,
  output logic             ID_EX_MemRead,
  output logic             ID_EX_MemWrite,
  output logic             ID_EX_MemtoReg,
  output logic             ID_EX_Branch,
  output logic             ID_EX_ALUSrc,
  output logic [1:0]       ID_EX_ALUOp,
  output logic             pc_write,
  output logic             if_id_write,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  ctrl_t id_ctrl;
  ctrl_t ex_ctrl;
  logic  load_use;
  logic  bubble;
  logic  clear;
  logic  capture;

  assign id_ctrl = '{reg_write: id_RegWrite, mem_read: id_MemRead, mem_write: id_MemWrite,
                     mem_to_reg: id_MemtoReg, branch: id_Branch, alu_src: id_ALUSrc,
                     alu_op: alu_op_e'(id_ALUOp)};

  load_use_detector u_lud (
    .ex_valid    (ID_EX_valid),
    .ex_mem_read (ex_ctrl.mem_read),
    .ex_rd       (ID_EX_RD),
    .id_valid    (if_id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_use_rs1  (id_use_rs1),
    .id_use_rs2  (id_use_rs2),
    .load_use    (load_use)
  );

  // A flush squashes the stall too, so upstream only waits on a hold in that case
  assign pc_write    = ~(ex_hold | (load_use & ~ex_flush));
  assign if_id_write = pc_write;

  assign bubble  = ~ex_flush & ~ex_hold & load_use;
  assign clear   = ex_flush | bubble;
  assign capture = ~ex_flush & ~ex_hold & ~load_use;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ID_EX_valid  <= 1'b0;
      ID_EX_PC     <= '0;
      ID_EX_RData1 <= '0;
      ID_EX_RData2 <= '0;
      ID_EX_Imm    <= '0;
      ID_EX_RS1    <= '0;
      ID_EX_RS2    <= '0;
      ID_EX_RD     <= '0;
      ex_ctrl      <= '0;
    end else if (clear) begin
      ID_EX_valid  <= 1'b0;
      ID_EX_PC     <= '0;
      ID_EX_RData1 <= '0;
      ID_EX_RData2 <= '0;
      ID_EX_Imm    <= '0;
      ID_EX_RS1    <= '0;
      ID_EX_RS2    <= '0;
      ID_EX_RD     <= '0;
      ex_ctrl      <= '0;
    end else if (capture) begin
      ID_EX_valid  <= if_id_valid;
      ID_EX_PC     <= id_pc;
      ID_EX_RData1 <= id_rdata1;
      ID_EX_RData2 <= id_rdata2;
      ID_EX_Imm    <= id_imm;
      ID_EX_RS1    <= id_rs1;
      ID_EX_RS2    <= id_rs2;
      ID_EX_RD     <= id_rd;
      ex_ctrl      <= if_id_valid ? id_ctrl : '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bubble_cnt <= '0;
      flush_cnt  <= '0;
    end else begin
      if (bubble && (bubble_cnt != '1)) bubble_cnt <= bubble_cnt + CNT_W'(1);
      if (ex_flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  assign ID_EX_RegWrite = ex_ctrl.reg_write;
  assign ID_EX_MemRead  = ex_ctrl.mem_read;
  assign ID_EX_MemWrite = ex_ctrl.mem_write;
  assign ID_EX_MemtoReg = ex_ctrl.mem_to_reg;
  assign ID_EX_Branch   = ex_ctrl.branch;
  assign ID_EX_ALUSrc   = ex_ctrl.alu_src;
  assign ID_EX_ALUOp    = ex_ctrl.alu_op;

endmodule
